// File: rtl/gf2m_mod_mult.sv
// Sequential GF(2^m) unit: MSB-first interleaved multiply, square, or XOR add.
// One operation in flight; valid/ready handshake on both operand and result sides.
module gf2m_mod_mult #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h002B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] b_sel;
  logic             is_mul;

  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
    xtime = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
  endfunction

  // op 00 and 10 run the shift/add loop; 01 and 11 are plain XOR.
  assign is_mul   = ~op[0];
  assign b_sel    = (op == 2'b10) ? A : B;
  assign acc_step = xtime(acc_q) ^ (b_q[cnt_q] ? a_q : '0);
  assign S        = s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = is_mul ? StCalc : StDone;
      StCalc: if (cnt_q == '0) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q == StCalc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      s_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q <= A;
            b_q <= b_sel;
            if (is_mul) begin
              acc_q <= '0;
              cnt_q <= CW'(WIDTH - 1);
            end else begin
              acc_q <= A ^ B;
              s_q   <= A ^ B;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - CW'(1);
          // S only changes on DONE entry so it holds the last result meanwhile.
          if (cnt_q == '0) s_q <= acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gf2m_mod_mult.md
Name: gf2m_mod_mult

Overview:
- Sequential GF(2^m) modular arithmetic unit; successor to the fixed 16-bit XOR slice.
- Width and reduction polynomial are parameters.
- Computes the field product (MSB-first interleaved shift/XOR/reduce), the field square, or the field sum (bitwise XOR) of two operands.
- Sits in the modular-multiplication datapath between operand staging and result consumers; valid/ready on both sides.

Parameters:
- WIDTH, 16, field degree m; operand/result width; legal range WIDTH >= 2.
- POLY, 16'h002B, low WIDTH bits of the reduction polynomial; the x^WIDTH term is implicit. Default is x^16+x^5+x^3+x+1.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and op present.
- in_ready  out  1  unit can accept operands.
- op  in  2  00 multiply A*B, 01 add A^B, 10 square A*A, 11 treated as add.
- A  in  WIDTH  operand A (polynomial, degree < WIDTH).
- B  in  WIDTH  operand B; ignored for op 10.
- out_valid  out  1  result S valid.
- out_ready  in  1  consumer accepts S.
- S  out  WIDTH  result.
- busy  out  1  high in CALC state.

Behaviour:
- Reset (rst_n low, async):
  - state IDLE; registers for A, B, acc and cnt cleared.
  - in_ready=1, out_valid=0, busy=0, S=0.
  - Reset mid-CALC or mid-DONE aborts the operation; no result is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch A, and latch B (or A for op 10).
  - Multiply/square: acc=0, cnt=WIDTH-1, go to CALC.
  - Add: acc=A^B, go directly to DONE.
- CALC:
  - in_ready=0, busy=1.
  - Each edge: acc = xtime(acc) ^ (Breg[cnt] ? Areg : 0), then cnt=cnt-1.
  - After the step with cnt==0, go to DONE.
  - Exactly WIDTH steps.
- xtime(v): shift v left 1 within WIDTH bits; if the old v[WIDTH-1] was 1, XOR the result with POLY. All arithmetic is carry-free.
- DONE:
  - out_valid=1; S=acc, held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE; out_valid drops and in_ready rises after that edge.
- Latency, counted from the accept edge to the edge after which out_valid=1:
  - WIDTH+1 edges for multiply/square.
  - 1 edge for add.
- Throughput: one operation in flight. At least one IDLE cycle sits between the output handshake and the next accept; no same-cycle turnaround.
- in_valid while in_ready=0 is ignored; the upstream holds the operands.
- out_ready while out_valid=0 has no effect.
- S is registered; it keeps the last result in IDLE and CALC until overwritten at the next DONE entry.
- Result is always fully reduced (degree < WIDTH). Operands need no pre-reduction because they are WIDTH bits wide.

Test Plan:
- Reset: hold rst_n=0, then release; also pulse rst_n low mid-CALC -> in_ready=1, out_valid=0, busy=0, S=0 immediately; the aborted operation yields no out_valid.
- Multiply, WIDTH=16, POLY=0x002B, out_ready=1:
  - A=0x0002, B=0x8000 -> S=0x002B.
  - A=0x8000, B=0x0004 -> S=0x0056.
  - A=0x0001, B=0x1234 -> S=0x1234.
  - out_valid on the 17th edge after accept; busy high for exactly 16 cycles.
- Square: op=10, A=0x0003, B=0xFFFF -> S=0x0005 (B ignored). Add: op=01, A=0x1234, B=0xFFFF -> S=0xEDCB with out_valid after 1 edge; op=11 with the same operands -> same result.
- Back-pressure: out_ready=0 for 10 cycles after DONE -> S and out_valid stable and in_ready=0 throughout, while in_valid pulses are ignored. Then out_ready=1 -> one handshake, then IDLE.
- Parametrisation: WIDTH=8, POLY=8'h1B; A=0x57, B=0x83 -> S=0xC1; A=0x02, B=0x80 -> S=0x1B; latency 9 edges.
- Random regression: 1000 back-to-back ops with random op, operands and in_valid/out_ready gaps -> every S matches a software GF(2^m) model; operation count in equals count out.
